// File: rtl/swt16_pkg.sv
// Shared swt16 definitions: arbiter FSM encoding, read latency and default
// memory geometry used by the arbiter and the top level.
package swt16_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 12;
  localparam int unsigned DEF_WORD_WIDTH = 16;
  localparam int unsigned ARB_LAT        = 1;

  typedef enum logic [0:0] {
    ARB_NORMAL  = 1'b0,
    ARB_IF_PRIO = 1'b1
  } arb_state_e;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear.
module arb_sat_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for the shared single-port memory with a fetch starvation guard.
// Optional activity counters are built when SWT16_ARB_STATS_EN is defined.
module mem_port_arbiter
  import swt16_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = DEF_ADDR_WIDTH,
  parameter int unsigned WORD_WIDTH       = DEF_WORD_WIDTH,
  parameter int unsigned MAX_STARVE       = 4,
  parameter int unsigned STARVE_CNT_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_flush,
  input  logic                  in_if_req,
  input  logic [ADDR_WIDTH-1:0] in_if_addr,
  output logic                  out_if_gnt,
  output logic                  out_if_rvalid,
  output logic [WORD_WIDTH-1:0] out_if_rdata,
  input  logic                  in_mem_req,
  input  logic                  in_mem_we,
  input  logic [ADDR_WIDTH-1:0] in_mem_addr,
  input  logic [WORD_WIDTH-1:0] in_mem_wdata,
  output logic                  out_mem_gnt,
  output logic                  out_mem_rvalid,
  output logic [WORD_WIDTH-1:0] out_mem_rdata,
  output logic                  out_ram_en,
  output logic                  out_ram_we,
  output logic [ADDR_WIDTH-1:0] out_ram_addr,
  output logic [WORD_WIDTH-1:0] out_ram_wdata,
`ifdef SWT16_ARB_STATS_EN
  output logic [15:0]           out_conflict_cnt,
  output logic [15:0]           out_forced_cnt,
`endif
  input  logic [WORD_WIDTH-1:0] in_ram_rdata
);

  arb_state_e                  state;
  arb_state_e                  state_next;
  logic                        if_gnt;
  logic                        mem_gnt;
  logic                        pend_if;
  logic                        pend_mem;
  logic [STARVE_CNT_WIDTH-1:0] starve_cnt;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ARB_NORMAL;
    end else begin
      state <= state_next;
    end
  end

  // Grant selection and next state; nothing is granted while reset is held
  always_comb begin
    state_next = state;
    if_gnt     = 1'b0;
    mem_gnt    = 1'b0;
    if (reset) begin
      case (state)
        ARB_NORMAL: begin
          if (in_mem_req) begin
            mem_gnt = 1'b1;
          end else if (in_if_req) begin
            if_gnt = 1'b1;
          end
          if (in_mem_req && in_if_req &&
              (starve_cnt == STARVE_CNT_WIDTH'(MAX_STARVE - 1))) begin
            state_next = ARB_IF_PRIO;
          end
        end
        ARB_IF_PRIO: begin
          if (in_if_req) begin
            if_gnt = 1'b1;
          end else if (in_mem_req) begin
            mem_gnt = 1'b1;
          end
          if (if_gnt || !in_if_req) begin
            state_next = ARB_NORMAL;
          end
        end
        default: state_next = ARB_NORMAL;
      endcase
    end
  end

  arb_sat_counter #(.WIDTH(STARVE_CNT_WIDTH)) u_starve_cnt (
    .clk   (clock),
    .rst_n (reset),
    .inc   (in_if_req & ~if_gnt),
    .clr   (if_gnt | ~in_if_req),
    .count (starve_cnt)
  );

  // Read-return tracking; a flush drops the fetch return scheduled for next cycle
  always_ff @(posedge clock) begin
    if (!reset) begin
      pend_if  <= 1'b0;
      pend_mem <= 1'b0;
    end else begin
      pend_if  <= if_gnt & ~in_flush;
      pend_mem <= mem_gnt & ~in_mem_we;
    end
  end

  assign out_if_gnt     = if_gnt;
  assign out_mem_gnt    = mem_gnt;
  assign out_ram_en     = if_gnt | mem_gnt;
  assign out_ram_we     = mem_gnt & in_mem_we;
  assign out_ram_addr   = mem_gnt ? in_mem_addr : (if_gnt ? in_if_addr : '0);
  assign out_ram_wdata  = (mem_gnt && in_mem_we) ? in_mem_wdata : '0;

  assign out_if_rvalid  = pend_if & reset;
  assign out_mem_rvalid = pend_mem & reset;
  assign out_if_rdata   = out_if_rvalid  ? in_ram_rdata : '0;
  assign out_mem_rdata  = out_mem_rvalid ? in_ram_rdata : '0;

`ifdef SWT16_ARB_STATS_EN
  arb_sat_counter #(.WIDTH(16)) u_conflict_cnt (
    .clk   (clock),
    .rst_n (reset),
    .inc   (in_if_req & in_mem_req),
    .clr   (1'b0),
    .count (out_conflict_cnt)
  );

  arb_sat_counter #(.WIDTH(16)) u_forced_cnt (
    .clk   (clock),
    .rst_n (reset),
    .inc   (if_gnt & (state == ARB_IF_PRIO)),
    .clr   (1'b0),
    .count (out_forced_cnt)
  );
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, synchronous-read unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the swt16 pipeline.
- Grants at most one access per cycle. Data accesses have priority over fetch, with a starvation guard that protects fetch.
- Routes read data back to whichever requester issued the read.
- Sits between the fetch and mem instances and the memory model at top level. Fetch stalls whenever it is not granted.

Parameters:
ADDR_WIDTH, 12, memory byte-address width (matches PMEM_ADDR_WIDTH)
WORD_WIDTH, 16, memory word width
MAX_STARVE, 4, consecutive denied fetch cycles before fetch gets forced priority; legal range 1..15
STARVE_CNT_WIDTH, 4, starvation counter width; must hold MAX_STARVE

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
in_flush  in  1  pipeline flush from exec; cancels any in-flight fetch read return
in_if_req  in  1  fetch requests an instruction read
in_if_addr  in  ADDR_WIDTH  fetch read address
out_if_gnt  out  1  fetch read issued this cycle (combinational)
out_if_rvalid  out  1  fetch read data valid (one cycle after grant)
out_if_rdata  out  WORD_WIDTH  fetch read data
in_mem_req  in  1  mem stage requests an access
in_mem_we  in  1  1 = write, 0 = read
in_mem_addr  in  ADDR_WIDTH  data address
in_mem_wdata  in  WORD_WIDTH  write data
out_mem_gnt  out  1  data access issued this cycle (combinational)
out_mem_rvalid  out  1  data read data valid (one cycle after a read grant)
out_mem_rdata  out  WORD_WIDTH  data read data
out_ram_en  out  1  memory enable
out_ram_we  out  1  memory write enable
out_ram_addr  out  ADDR_WIDTH  memory address
out_ram_wdata  out  WORD_WIDTH  memory write data
in_ram_rdata  in  WORD_WIDTH  memory read data; registered inside the memory, valid the cycle after enable

Behaviour:
- Reset (reset==0 at a clock edge):
  - FSM goes to NORMAL, starve_cnt=0, both pending flags=0.
  - While reset is low, all grant, valid and ram outputs are forced to 0 and rdata outputs are 0.
  - A read in flight when reset asserts never produces a valid.
- FSM states:
  - NORMAL: if in_mem_req, grant mem; else if in_if_req, grant fetch.
  - IF_PRIO: if in_if_req, grant fetch; else if in_mem_req, grant mem.
  - NORMAL -> IF_PRIO: at a clock edge where both requests are high, mem is granted, and starve_cnt == MAX_STARVE-1.
  - IF_PRIO -> NORMAL: at the edge after any fetch grant, or when in_if_req is low.
- starve_cnt:
  - Increments, saturating, on every cycle where in_if_req=1 and out_if_gnt=0.
  - Clears on a fetch grant or when in_if_req=0.
- Grants are combinational from the current requests and state. Exactly one of out_if_gnt / out_mem_gnt may be high; never both.
- RAM drive:
  - out_ram_en = either grant.
  - out_ram_we = out_mem_gnt & in_mem_we.
  - out_ram_addr and out_ram_wdata are muxed from the granted requester. out_ram_wdata is 0 unless a write is granted.
- Read return:
  - pend_if and pend_mem are registered at grant time. Set pend_if on a fetch grant; set pend_mem on a mem read grant.
  - On the next cycle, out_*_rvalid equals the corresponding pending flag, and out_*_rdata = in_ram_rdata gated by rvalid (0 otherwise).
  - Latency is fixed at 1 cycle. Back-to-back grants are allowed every cycle.
- Writes produce no rvalid; out_mem_gnt is the write acknowledge.
- Flush:
  - in_flush=1 clears pend_if at the next edge, so a fetch return scheduled for the next cycle is suppressed. It does not affect pend_mem.
  - A fetch grant in the flush cycle is still issued to RAM, but its return is dropped.
- Requesters hold req, address and data stable until they are granted; the arbiter does not latch a request that is not granted.
- MAX_STARVE=1: every conflict alternates mem, fetch, mem, fetch.

Optional Feature:
- Macro: SWT16_ARB_STATS_EN.
- With the macro defined:
  - Adds output out_conflict_cnt [15:0], a saturating count of cycles with both requests high.
  - Adds output out_forced_cnt [15:0], a saturating count of IF_PRIO-forced fetch grants.
  - Both counters reset to 0.
- Without the macro: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package swt16_pkg holds:
  - the FSM state encoding (ARB_NORMAL, ARB_IF_PRIO);
  - ARB_LAT=1;
  - the default ADDR_WIDTH and WORD_WIDTH constants shared with top level.
- Sub-module arb_sat_counter (parameterised width, inc, clr, saturate) is used for starve_cnt and both stats counters.

Test Plan:
- Fetch only: in_if_req=1 for 5 cycles, addresses 0,2,4,6,8 -> out_if_gnt=1 each cycle; out_if_rvalid=1 on cycles 2..6 with in_ram_rdata passed through; out_mem_rvalid=0 throughout.
- Mem write then read: write addr 0x010, data 0xBEEF, then read 0x010 -> out_ram_we=1 only in the write cycle; out_mem_rvalid=1 one cycle after the read grant, carrying 0xBEEF from the memory model.
- Conflict with starvation guard: MAX_STARVE=4, both requests held high -> mem granted for 4 cycles, fetch granted on cycle 5, mem granted on cycle 6; in the stats build, out_forced_cnt=1 and out_conflict_cnt=6.
- Flush: fetch granted at cycle N and in_flush=1 at cycle N -> out_if_rvalid=0 at N+1; a mem read granted at N still gives out_mem_rvalid=1 at N+1.
- Reset mid-read: mem read granted, reset=0 on the following edge -> out_mem_rvalid=0, all grants and ram outputs 0; after release, NORMAL with starve_cnt=0.
- Mutual exclusion: random in_if_req/in_mem_req/in_mem_we for 10k cycles -> assert never out_if_gnt & out_mem_gnt, and each rvalid arrives exactly 1 cycle after the matching read grant unless flushed or reset.
